// File: rtl/tpu_result_drain_if.sv
// tpu_result_drain_if: valid/ready result stream carrying one requantized column per transfer
//   data  : requantized word
//   idx   : column index of data
//   valid : data/idx/last are meaningful
//   ready : consumer accepts the word when valid && ready
//   last  : final column of the vector
//   master modport = producer (drain), slave modport = consumer
interface tpu_result_drain_if #(
    parameter int N         = 4,
    parameter int OUT_WIDTH = 16
) ();
    logic [OUT_WIDTH-1:0] data;
    logic [$clog2(N)-1:0] idx;
    logic                 valid;
    logic                 ready;
    logic                 last;
    modport master (output data, idx, valid, last, input ready);
    modport slave  (input data, idx, valid, last, output ready);
endinterface

// File: rtl/tpu_result_drain.sv
// tpu_result_drain: captures the systolic array's accumulator vector, requantizes each column
// (logical right shift then unsigned saturate) and streams the columns out one per transfer.
//   clk, rst  : clock, synchronous active-high reset
//   acc_in    : N columns of ACC_WIDTH bits, column 0 in the low bits
//   acc_valid : one-cycle strobe marking a complete vector on acc_in
//   out       : result stream (master side of tpu_result_drain_if)
//   busy      : high while draining
//   overrun   : sticky, a vector arrived while it could not be captured
//   sat_count : only with TPU_DRAIN_SAT_CNT_EN, running count of saturated columns (wraps)
module tpu_result_drain #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*ACC_WIDTH-1:0] acc_in,
    input  logic                   acc_valid,
    tpu_result_drain_if.master     out,
    output logic                   busy,
    output logic                   overrun
`ifdef TPU_DRAIN_SAT_CNT_EN
    ,
    output logic [15:0]            sat_count
`endif
);
    localparam int IW = $clog2(N);
    localparam logic [ACC_WIDTH-1:0] MAX = {ACC_WIDTH{1'b1}} >> (ACC_WIDTH - OUT_WIDTH);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [OUT_WIDTH-1:0] buffer [N];
    logic [OUT_WIDTH-1:0] quant  [N];
    logic [N-1:0]         sat;
    logic [ACC_WIDTH-1:0] r;
    logic                 fire, final_hs, capture, overrun_n;

    // Requantization happens on the input side so the output path is a plain buffer read.
    always_comb begin
        r   = '0;
        sat = '0;
        for (int k = 0; k < N; k++) begin
            r        = acc_in[k*ACC_WIDTH +: ACC_WIDTH] >> SHIFT;
            sat[k]   = r > MAX;
            quant[k] = sat[k] ? MAX[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
        end
    end

    // A vector arriving on the final handshake is captured, giving gap-free back-to-back drains.
    always_comb begin
        fire      = out.valid && out.ready;
        final_hs  = fire && idx == IW'(N - 1);
        capture   = acc_valid && (state == IDLE || final_hs);
        overrun_n = overrun || (acc_valid && state == DRAIN && !final_hs);
        state_n   = capture ? DRAIN : final_hs ? IDLE : state;
        idx_n     = (capture || final_hs) ? '0 : fire ? idx + 1'b1 : idx;
        out.valid = state == DRAIN;
        out.idx   = idx;
        out.last  = out.valid && idx == IW'(N - 1);
        out.data  = out.valid ? buffer[idx] : '0;
        busy      = state == DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            overrun <= overrun_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && capture) buffer <= quant;
    end

`ifdef TPU_DRAIN_SAT_CNT_EN
    logic [15:0] sat_add;

    always_comb begin
        sat_add = '0;
        for (int k = 0; k < N; k++) sat_add = sat_add + 16'(sat[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) sat_count <= '0;
        else if (capture) sat_count <= sat_count + sat_add;
    end
`endif
endmodule

// File: tb/tb_tpu_result_drain.sv
// tb_tpu_result_drain: directed bench for tpu_result_drain (SHIFT=0 and SHIFT=2 instances in lockstep)
module tb_tpu_result_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] acc_in = '0;
    logic        acc_valid = 1'b0;
    logic        busy0, ov0, busy1, ov1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    tpu_result_drain_if #(.N(4), .OUT_WIDTH(16)) o0 ();
    tpu_result_drain_if #(.N(4), .OUT_WIDTH(16)) o1 ();

`ifdef TPU_DRAIN_SAT_CNT_EN
    logic [15:0] sc0, sc1, base0, base1;
`endif

    tpu_result_drain #(.N(4), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid),
        .out(o0.master), .busy(busy0), .overrun(ov0)
`ifdef TPU_DRAIN_SAT_CNT_EN
        , .sat_count(sc0)
`endif
    );

    tpu_result_drain #(.N(4), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid),
        .out(o1.master), .busy(busy1), .overrun(ov1)
`ifdef TPU_DRAIN_SAT_CNT_EN
        , .sat_count(sc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        o0.ready = r;
        o1.ready = r;
    endtask

    task automatic load(input logic [23:0] a0, a1, a2, a3);
        acc_in    = {a3, a2, a1, a0};
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic see(input string tag, input logic [15:0] d, input int k);
        check({tag, "_valid"}, 32'(o0.valid), 1);
        check({tag, "_data"}, 32'(o0.data), 32'(d));
        check({tag, "_idx"}, 32'(o0.idx), k);
        check({tag, "_last"}, 32'(o0.last), 32'(k == 3));
        check({tag, "_busy"}, 32'(busy0), 1);
    endtask

    task automatic idle_state(input string tag, input logic ov);
        check({tag, "_valid"}, 32'(o0.valid), 0);
        check({tag, "_idx"}, 32'(o0.idx), 0);
        check({tag, "_data"}, 32'(o0.data), 0);
        check({tag, "_last"}, 32'(o0.last), 0);
        check({tag, "_busy"}, 32'(busy0), 0);
        check({tag, "_ovr"}, 32'(ov0), 32'(ov));
    endtask

    logic [15:0] t1 [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [15:0] tb [4] = '{16'd11, 16'd22, 16'd33, 16'd44};
    logic [15:0] s0 [4] = '{16'hFFFF, 16'hFFFF, 16'd400, 16'hFFFF};
    logic [15:0] s2 [4] = '{16'h3FFF, 16'h48D1, 16'd100, 16'hFFFF};
    logic        rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int          n;
        logic [15:0] pd;
        logic [1:0]  pi;
        set_ready(1'b1);
        tick();
        idle_state("rst", 1'b0);
        rst = 1'b0;
        tick();
        // basic drain
        load(24'd100, 24'd200, 24'd300, 24'd400);
        for (int k = 0; k < 4; k++) begin
            see("basic", t1[k], k);
            tick();
        end
        idle_state("basic_end", 1'b0);
        // backpressure
        load(24'd100, 24'd200, 24'd300, 24'd400);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            set_ready(rdy[i]);
            if (rdy[i]) begin
                see("bp", t1[n], n);
                n++;
            end
            pd = o0.data;
            pi = o0.idx;
            tick();
            if (!rdy[i]) begin
                check("bp_hold_data", 32'(o0.data), 32'(pd));
                check("bp_hold_idx", 32'(o0.idx), 32'(pi));
            end
        end
        set_ready(1'b1);
        check("bp_count", n, 4);
        idle_state("bp_end", 1'b0);
        // saturation and shift
`ifdef TPU_DRAIN_SAT_CNT_EN
        base0 = sc0;
        base1 = sc1;
`endif
        load(24'h00FFFF, 24'h012345, 24'd400, 24'hFFFFFF);
`ifdef TPU_DRAIN_SAT_CNT_EN
        check("satcnt0", 32'(sc0), 32'(base0 + 16'd2));
        check("satcnt1", 32'(sc1), 32'(base1 + 16'd1));
`endif
        for (int k = 0; k < 4; k++) begin
            see("sat0", s0[k], k);
            check("sat2_data", 32'(o1.data), 32'(s2[k]));
            check("sat2_idx", 32'(o1.idx), k);
            tick();
        end
        idle_state("sat_end", 1'b0);
        // back-to-back, then overrun
        load(24'd100, 24'd200, 24'd300, 24'd400);
        for (int k = 0; k < 4; k++) begin
            see("b2b_a", t1[k], k);
            if (k == 3) begin
                acc_in    = {24'd44, 24'd33, 24'd22, 24'd11};
                acc_valid = 1'b1;
            end
            tick();
            acc_valid = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            see("b2b_b", tb[k], k);
            check("b2b_ovr", 32'(ov0), 32'(k > 1));
            if (k == 1) begin
                acc_in    = {24'd9, 24'd8, 24'd7, 24'd6};
                acc_valid = 1'b1;
            end
            tick();
            acc_valid = 1'b0;
        end
        idle_state("ovr_end", 1'b1);
        // reset mid-drain, acc_valid alongside rst must be ignored
        load(24'd100, 24'd200, 24'd300, 24'd400);
        tick();
        tick();
        see("pre_rst", t1[2], 2);
        rst       = 1'b1;
        acc_valid = 1'b1;
        tick();
        rst       = 1'b0;
        acc_valid = 1'b0;
        idle_state("mid_rst", 1'b0);
        tick();
        idle_state("post_rst", 1'b0);
        load(24'd11, 24'd22, 24'd33, 24'd44);
        for (int k = 0; k < 4; k++) begin
            see("fresh", tb[k], k);
            tick();
        end
        idle_state("fresh_end", 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
